// File: rtl/hilo_mdu_if.sv
// Core-side bundle of the HI/LO multiply/divide unit: request, MTHI/MTLO writes, status and HI/LO.
// No latency of its own; the core stalls on busy.
// The core drives requests as master, and the MDU answers as slave.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative MULT/MULTU/DIV/DIVU owning HI/LO, one bit per cycle; the divider is compiled in only with MDU_DIV_EN.
// Latency WIDTH+2 cycles from the start cycle to the done pulse (divide without MDU_DIV_EN: done the next cycle).
// start is ignored while busy, and flush aborts the operation from any state.
module hilo_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic      clk,
    input  logic      rst,
    hilo_mdu_if.slave mdu
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, SIGN = 2'd2} stateT;

    stateT              state, stateNext;
    logic               busyReg, doneReg, busyNext, doneNext, accept;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc, mcand, accNext, prod;
    logic [WIDTH-1:0]   opB, hiReg, loReg, hiRes, loRes, absA, absB;
    logic               negRes, signedOp;
`ifdef MDU_DIV_EN
    logic               isDiv, negRem, divZero;
    logic [WIDTH-1:0]   rawA, quo, rem;
    logic [WIDTH:0]     remShift, remDiff;
`endif

    assign signedOp = mdu.op[0];
    assign absA     = (signedOp && mdu.a[WIDTH-1]) ? -mdu.a : mdu.a;
    assign absB     = (signedOp && mdu.b[WIDTH-1]) ? -mdu.b : mdu.b;

    assign mdu.busy = busyReg;
    assign mdu.done = doneReg;
    assign mdu.hi   = hiReg;
    assign mdu.lo   = loReg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busyReg <= 1'b0;
            doneReg <= 1'b0;
        end else begin
            state   <= stateNext;
            busyReg <= busyNext;
            doneReg <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        busyNext  = busyReg;
        doneNext  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                busyNext = 1'b0;
                if (mdu.start && !mdu.flush) begin
                    accept = 1'b1;
`ifdef MDU_DIV_EN
                    stateNext = CALC;
                    busyNext  = 1'b1;
`else
                    // Divide requests complete immediately with HI/LO untouched.
                    if (mdu.op[1]) begin
                        doneNext = 1'b1;
                    end else begin
                        stateNext = CALC;
                        busyNext  = 1'b1;
                    end
`endif
                end
            end
            CALC: begin
                if (mdu.flush) begin
                    stateNext = IDLE;
                    busyNext  = 1'b0;
                end else if (cnt == LAST_CNT) begin
                    stateNext = SIGN;
                end
            end
            SIGN: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
                doneNext  = !mdu.flush;
            end
            default: begin
                stateNext = IDLE;
                busyNext  = 1'b0;
            end
        endcase
    end

    always_comb begin
        accNext = acc + (opB[0] ? mcand : '0);
        prod    = negRes ? -acc : acc;
        hiRes   = prod[2*WIDTH-1:WIDTH];
        loRes   = prod[WIDTH-1:0];
`ifdef MDU_DIV_EN
        // acc holds {remainder, dividend bits still to consume / quotient bits produced}.
        remShift = acc[2*WIDTH-1:WIDTH-1];
        remDiff  = remShift - {1'b0, opB};
        quo      = negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem      = negRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        if (isDiv) begin
            accNext = remDiff[WIDTH] ? {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {remDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            if (divZero) begin
                hiRes = rawA;
                loRes = '1;
            end else begin
                hiRes = rem;
                loRes = quo;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            mcand   <= '0;
            opB     <= '0;
            negRes  <= 1'b0;
            hiReg   <= '0;
            loReg   <= '0;
`ifdef MDU_DIV_EN
            isDiv   <= 1'b0;
            negRem  <= 1'b0;
            divZero <= 1'b0;
            rawA    <= '0;
`endif
        end else begin
            if (accept) begin
                cnt    <= '0;
                mcand  <= {{WIDTH{1'b0}}, absA};
                opB    <= absB;
                negRes <= signedOp & (mdu.a[WIDTH-1] ^ mdu.b[WIDTH-1]);
`ifdef MDU_DIV_EN
                isDiv   <= mdu.op[1];
                acc     <= mdu.op[1] ? {{WIDTH{1'b0}}, absA} : '0;
                negRem  <= signedOp & mdu.a[WIDTH-1];
                divZero <= (mdu.b == '0);
                rawA    <= mdu.a;
`else
                acc     <= '0;
`endif
            end else if (state == CALC) begin
                cnt   <= cnt + 1'b1;
                acc   <= accNext;
                mcand <= mcand << 1;
`ifdef MDU_DIV_EN
                if (!isDiv) opB <= opB >> 1;
`else
                opB   <= opB >> 1;
`endif
            end

            // MTHI/MTLO land only in IDLE, which also covers the start cycle itself.
            if (state == IDLE) begin
                if (mdu.hi_we) hiReg <= mdu.wdata;
                if (mdu.lo_we) loReg <= mdu.wdata;
            end else if (state == SIGN && !mdu.flush) begin
                hiReg <= hiRes;
                loReg <= loRes;
            end
        end
    end
endmodule

// File: tb/tb_hilo_mdu.sv
// Directed bench for hilo_mdu at WIDTH=32: expected HI/LO pushed at issue and popped on done.
// Works with or without MDU_DIV_EN.
module tb_hilo_mdu;
    logic clk;
    logic rst;
    hilo_mdu_if #(.WIDTH(32)) bus();

    hilo_mdu #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .mdu (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [63:0] sb[$];
    logic [31:0] curHi = '0;
    logic [31:0] curLo = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        int          sq, sr;
        case (o)
            2'b00: r = {32'b0, x} * {32'b0, y};
            2'b01: r = {{32{x[31]}}, x} * {{32{y[31]}}, y};
            2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    sq = $signed(x) / $signed(y);
                    sr = $signed(x) % $signed(y);
                    r  = {sr, sq};
                end
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // n counts cycles since the start cycle; returns in the done cycle or on timeout.
    task automatic waitDone(input string tag, input int n0, input int expLat, output int busyCnt);
        int          n;
        logic [63:0] e;
        n       = n0;
        busyCnt = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            if (bus.busy === 1'b1) busyCnt++;
            tick();
            n++;
        end
        check($sformatf("%s_latency", tag), 64'(n), 64'(expLat));
        check($sformatf("%s_busy_at_done", tag), 64'(bus.busy), 64'(0));
        e = (sb.size() > 0) ? sb.pop_front() : 64'bx;
        check($sformatf("%s_hilo", tag), {bus.hi, bus.lo}, e);
        {curHi, curLo} = e;
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [63:0] exp);
        int bc;
        sb.push_back(exp);
        issue(o, x, y);
        waitDone(tag, 1, 34, bc);
        check($sformatf("%s_busy_cycles", tag), 64'(bc), 64'(33));
    endtask

    task automatic quiet(input string tag, input int cycles);
        int seen;
        seen = 0;
        repeat (cycles) begin
            if (bus.done === 1'b1) seen++;
            tick();
        end
        check(tag, 64'(seen), 64'(0));
    endtask

    initial begin
        int          bc;
        logic [1:0]  o;
        logic [31:0] x, y;

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.flush = 1'b0;
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        check("reset_busy_done", {62'b0, bus.busy, bus.done}, 64'(0));
        check("reset_hilo", {bus.hi, bus.lo}, 64'(0));
        rst = 1'b0;
        tick();

        runOp("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        tick();
        check("done_one_cycle", 64'(bus.done), 64'(0));
        runOp("mult_neg3x7", 2'b01, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        runOp("mult_min_sq", 2'b01, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);

`ifdef MDU_DIV_EN
        runOp("div_neg7_2", 2'b11, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("divu_by_zero", 2'b10, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        runOp("div_overflow", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        runOp("div_by_zero", 2'b11, 32'hFFFF_FFF0, 32'd0, 64'hFFFF_FFF0_FFFF_FFFF);
`else
        issue(2'b10, 32'd9, 32'd3);
        check("nodiv_done_n1", {62'b0, bus.busy, bus.done}, 64'(1));
        check("nodiv_hilo_kept", {bus.hi, bus.lo}, {curHi, curLo});
        tick();
        check("nodiv_done_gone", {62'b0, bus.busy, bus.done}, 64'(0));
`endif
        runOp("multu_3x5", 2'b00, 32'd3, 32'd5, 64'd15);

        // Flush mid-operation with preloaded HI/LO.
        bus.hi_we = 1'b1; bus.wdata = 32'h11; tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h22; tick();
        bus.lo_we = 1'b0;
        check("mthi_mtlo", {bus.hi, bus.lo}, {32'h11, 32'h22});
        issue(2'b00, 32'd5, 32'd5);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy_low", 64'(bus.busy), 64'(0));
        quiet("flush_no_done", 40);
        check("flush_hilo_kept", {bus.hi, bus.lo}, {32'h11, 32'h22});
        bus.flush = 1'b1;
        issue(2'b00, 32'd2, 32'd2);
        bus.flush = 1'b0;
        check("flush_start_rejected", 64'(bus.busy), 64'(0));
        quiet("flush_start_no_done", 40);

        // Ignored start and MTHI while busy, then a start in the done cycle.
        sb.push_back(model(2'b00, 32'd6, 32'd7));
        issue(2'b00, 32'd6, 32'd7);
        repeat (3) tick();
        bus.start = 1'b1; bus.a = 32'd1; bus.b = 32'd1;
        bus.hi_we = 1'b1; bus.wdata = 32'hDEAD;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        check("mthi_ignored_busy", 64'(bus.hi), 64'(32'h11));
        waitDone("ignored_start", 5, 34, bc);
        x = 32'h1234_5678; y = 32'h9ABC_DEF0;
        sb.push_back(model(2'b00, x, y));
        bus.hi_we = 1'b1; bus.wdata = 32'h55;
        issue(2'b00, x, y);
        bus.hi_we = 1'b0;
        check("mthi_with_start", 64'(bus.hi), 64'(32'h55));
        waitDone("back_to_back", 1, 34, bc);
        check("back_to_back_busy", 64'(bc), 64'(33));

        for (int i = 0; i < 6; i++) begin
`ifdef MDU_DIV_EN
            o = 2'($urandom_range(0, 3));
`else
            o = 2'($urandom_range(0, 1));
`endif
            x = $urandom();
            y = (i == 2) ? 32'($urandom_range(0, 9)) : $urandom();
            runOp($sformatf("rand%0d_op%0d", i, o), o, x, y, model(o, x, y));
        end

        // Reset in the middle of CALC.
        issue(2'b00, 32'd100, 32'd100);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy_done", {62'b0, bus.busy, bus.done}, 64'(0));
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'(0));
        quiet("rst_mid_no_done", 40);
        runOp("after_reset", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no completion, required finish before 500000 ns");
        $fatal(1, "watchdog");
    end
endmodule
